// File: rtl/dram_pkg.sv
// Shared types and geometry for the TMS4464 (64Kx4) responder model.
package dram_pkg;

  localparam int ROW_W = 8;
  localparam int COL_W = 8;
  localparam int DQ_W  = 4;
  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    ROW,
    COL,
    CBR_WAIT,
    CBR,
    PRE
  } resp_state_t;

  typedef enum logic [2:0] {
    V_NONE    = 3'd0,
    V_TRAS    = 3'd1,
    V_TCAS    = 3'd2,
    V_TRP     = 3'd3,
    V_LATE_WR = 3'd4,
    V_REFRESH = 3'd5
  } viol_t;

  // Timing counters stop at all-ones so a long strobe never wraps into a false short one.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction

endpackage

// File: rtl/dram_store.sv
// Single-port synchronous RAM, one-cycle read latency, backing store for the responder.
module dram_store
  import dram_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic            clk,
  input  logic            we,
  input  logic            re,
  input  logic [AW-1:0]   addr,
  input  logic [DQ_W-1:0] wdata,
  output logic [DQ_W-1:0] rdata
);

  logic [DQ_W-1:0] mem [2**AW];

  // Write-or-read port; the read register only updates when a read is issued.
  // NOTE: the array and its read register have no reset; a reset would block RAM inference,
  // and a real DRAM powers up with arbitrary contents anyway.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/dram4464_responder.sv
// TMS4464 DRAM device emulator: answers the RAS/CAS/WE/OE bus, stores data and
// flags protocol/timing violations. Optional refresh-interval checking is
// enabled by defining DRAM_REFRESH_CHECK_EN.
module dram4464_responder
  import dram_pkg::*;
#(
  parameter int MEM_AW        = 12,
  parameter int T_RAS_MIN     = 5,
  parameter int T_CAS_MIN     = 2,
  parameter int T_RP_MIN      = 4,
  parameter int REFRESH_LIMIT = 800
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ROW_W-1:0] ram_addr,
  input  logic             ram_ras_,
  input  logic             ram_cas_,
  input  logic             ram_we_,
  input  logic             ram_oe_,
  input  logic [DQ_W-1:0]  dq_in,
  output logic [DQ_W-1:0]  dq_out,
  output logic             dq_oe,
  output logic             viol,
  output logic [2:0]       viol_code,
  input  logic             viol_clr,
  output logic [15:0]      refresh_cnt
);

  logic             ras_q, cas_q, we_q;
  logic             ras_fall, ras_rise, cas_fall, cas_rise, we_fall;
  logic [CNT_W-1:0] ras_cnt, cas_cnt, pre_cnt;
  resp_state_t      state;
  logic [ROW_W-1:0] row_q;
  logic             access_go, mem_we, rd_issue, rd_pending;
  logic [MEM_AW-1:0] mem_addr;
  logic [DQ_W-1:0]  rd_data;
  logic             cbr_exit, refresh_ev, overdue;
  logic [9:0]       since_cbr;
  viol_t            viol_new;

  assign ras_fall = ras_q & ~ram_ras_;
  assign ras_rise = ~ras_q & ram_ras_;
  assign cas_fall = cas_q & ~ram_cas_;
  assign cas_rise = ~cas_q & ram_cas_;
  assign we_fall  = we_q & ~ram_we_;

  // Column strobe of a normal access; a simultaneous ras rise cancels it.
  assign access_go = (state == ROW) && cas_fall && !ram_ras_;
  assign mem_we    = access_go && !ram_we_;
  assign rd_issue  = access_go && ram_we_;
  assign mem_addr  = MEM_AW'({row_q, ram_addr});
  assign cbr_exit  = (state == CBR) && ras_rise;

  dram_store #(.AW(MEM_AW)) u_store (
    .clk   (clk),
    .we    (mem_we),
    .re    (rd_issue),
    .addr  (mem_addr),
    .wdata (dq_in),
    .rdata (rd_data)
  );

  // Strobe history and saturating low/high duration counters.
  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ras_q   <= 1'b1;
      cas_q   <= 1'b1;
      we_q    <= 1'b1;
      ras_cnt <= '0;
      cas_cnt <= '0;
      pre_cnt <= '1;
    end else begin
      ras_q <= ram_ras_;
      cas_q <= ram_cas_;
      we_q  <= ram_we_;
      if (ras_fall)      ras_cnt <= CNT_W'(1);
      else if (!ram_ras_) ras_cnt <= sat_inc(ras_cnt);
      if (ras_rise)      pre_cnt <= CNT_W'(1);
      else if (ram_ras_) pre_cnt <= sat_inc(pre_cnt);
      if (cas_fall)      cas_cnt <= CNT_W'(1);
      else if (!ram_cas_) cas_cnt <= sat_inc(cas_cnt);
    end
  end

`ifdef DRAM_REFRESH_CHECK_EN
  // Cycles since the last completed CBR refresh, saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    since_cbr <= '0;
    else if (cbr_exit)          since_cbr <= '0;
    else if (since_cbr != '1)   since_cbr <= since_cbr + 10'd1;
  end
`else
  assign since_cbr = '0;
`endif

  assign overdue    = since_cbr > 10'(REFRESH_LIMIT);
  assign refresh_ev = (since_cbr == 10'(REFRESH_LIMIT)) && !cbr_exit;

  // Violation raised this cycle; the lowest code wins if several coincide.
  // NOTE: viol_new gets a default before any branch so no path infers a latch.
  always_comb begin
    viol_new = V_NONE;
    if (ras_rise && ras_cnt < CNT_W'(T_RAS_MIN))
      viol_new = V_TRAS;
    else if (state == COL && cas_rise && !ras_rise && cas_cnt < CNT_W'(T_CAS_MIN))
      viol_new = V_TCAS;
    else if (ras_fall && pre_cnt < CNT_W'(T_RP_MIN))
      viol_new = V_TRP;
    else if (state == COL && we_fall)
      viol_new = V_LATE_WR;
    else if (refresh_ev)
      viol_new = V_REFRESH;
  end

  // Access FSM with registered bus outputs, violation latch and refresh count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      row_q       <= '0;
      rd_pending  <= 1'b0;
      dq_out      <= '0;
      dq_oe       <= 1'b0;
      viol        <= 1'b0;
      viol_code   <= V_NONE;
      refresh_cnt <= '0;
    end else begin
      rd_pending <= rd_issue;
      if (rd_pending) dq_out <= overdue ? ~rd_data : rd_data;
      dq_oe <= (state == COL) && !ram_oe_ && ram_we_;

      if (viol_clr) begin
        viol      <= (viol_new != V_NONE);
        viol_code <= viol_new;
      end else if (!viol && viol_new != V_NONE) begin
        viol      <= 1'b1;
        viol_code <= viol_new;
      end

      case (state)
        IDLE, PRE: begin
          if (ras_fall) begin
            row_q <= ram_addr;
            state <= ram_cas_ ? ROW : CBR_WAIT;
          end else if (state == PRE && ram_ras_ && pre_cnt >= CNT_W'(T_RP_MIN)) begin
            state <= IDLE;
          end else if (cas_fall) begin
            state <= CBR_WAIT;
          end
        end
        CBR_WAIT: begin
          if (!ram_ras_)     state <= CBR;
          else if (ras_rise) state <= PRE;
          else if (cas_rise) state <= IDLE;
        end
        ROW: begin
          if (ras_rise)      state <= PRE;
          else if (cas_fall) state <= COL;
        end
        COL: begin
          if (ras_rise)      state <= PRE;
          else if (cas_rise) state <= ROW;
        end
        CBR: begin
          if (ras_rise) begin
            state       <= PRE;
            refresh_cnt <= refresh_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
